// File: rtl/uartUtil.sv
// UART shared types: line-state, parity-mode and transmit-FSM encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uartUtil;

  // Generic line-state encoding used by existing receive-side logic.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } states_t;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } txState_t;

endpackage

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Latency: frame starts on the first baudTick at least one cycle after accept.
// Backpressure: txReady low while the one-entry holding register is full.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   baudTick        - one-cycle enable per bit period
//   txValid/txData  - upstream word, accepted when txValid && txReady
//   txReady         - holding register empty
//   transmitOutput  - registered serial line, idle high
//   busy            - FSM not idle
//   frameDone       - one-cycle pulse after the last stop bit
module uart_tx_framer
  import uartUtil::*;
#(
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baudTick,
  input  logic                 txValid,
  input  logic [DATA_BITS-1:0] txData,
  output logic                 txReady,
  output logic                 transmitOutput,
  output logic                 busy,
  output logic                 frameDone
);

  localparam int             BCW        = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATA_BITS - 1);
  localparam logic           STOP_LAST  = 1'(STOP_BITS - 1);
  localparam bit             HAS_PARITY = (PARITY != PARITY_NONE);

  txState_t             state;
  logic [DATA_BITS-1:0] holdReg;
  logic [DATA_BITS-1:0] shifter;
  logic                 holdFull;
  logic                 parityBit;
  logic [BCW-1:0]       bitCnt;
  logic                 stopCnt;

  logic accept;
  logic frameEnd;
  logic load;

  function automatic logic calcParity(input logic [DATA_BITS-1:0] d);
    return (PARITY == PARITY_ODD) ? ~^d : ^d;
  endfunction

  assign txReady  = !holdFull;
  assign busy     = (state != TX_IDLE);
  assign accept   = txValid && !holdFull;
  assign frameEnd = (state == TX_STOP) && (stopCnt == STOP_LAST);
  // The shifter is reloaded either from idle or directly out of the final
  // stop bit, which gives back-to-back frames with no idle bit between them.
  assign load     = baudTick && holdFull && ((state == TX_IDLE) || frameEnd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= TX_IDLE;
      holdReg        <= '0;
      shifter        <= '0;
      holdFull       <= 1'b0;
      parityBit      <= 1'b0;
      bitCnt         <= '0;
      stopCnt        <= 1'b0;
      transmitOutput <= 1'b1;
      frameDone      <= 1'b0;
    end else begin
      frameDone <= baudTick && frameEnd;

      // Accept needs an empty register and load needs a full one, so the two
      // updates of holdFull below can never collide.
      if (accept) begin
        holdReg  <= txData;
        holdFull <= 1'b1;
      end

      if (load) begin
        state          <= TX_START;
        shifter        <= holdReg;
        parityBit      <= calcParity(holdReg);
        holdFull       <= 1'b0;
        transmitOutput <= 1'b0;
      end else if (baudTick) begin
        unique case (state)
          TX_IDLE: begin
            transmitOutput <= 1'b1;
          end
          TX_START: begin
            state          <= TX_DATA;
            bitCnt         <= '0;
            transmitOutput <= shifter[0];
          end
          TX_DATA: begin
            shifter <= shifter >> 1;
            if (bitCnt == BIT_LAST) begin
              if (HAS_PARITY) begin
                state          <= TX_PARITY;
                transmitOutput <= parityBit;
              end else begin
                state          <= TX_STOP;
                stopCnt        <= 1'b0;
                transmitOutput <= 1'b1;
              end
            end else begin
              bitCnt         <= bitCnt + 1'b1;
              // Line is registered, so present the bit that the shift exposes.
              transmitOutput <= shifter[1];
            end
          end
          TX_PARITY: begin
            state          <= TX_STOP;
            stopCnt        <= 1'b0;
            transmitOutput <= 1'b1;
          end
          TX_STOP: begin
            if (frameEnd) begin
              state          <= TX_IDLE;
              transmitOutput <= 1'b1;
            end else begin
              stopCnt <= stopCnt + 1'b1;
            end
          end
          default: begin
            state          <= TX_IDLE;
            transmitOutput <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: six parameter/tick-rate configurations run in
// parallel, each against a frame-level model (queue of line bits per word).
module tb_uart_tx_framer;
  import uartUtil::*;

  typedef bit bitq_t[$];

  localparam int NI = 6;
  localparam int DBS    [NI] = '{8, 8, 8, 8, 7, 9};
  localparam int PARS_I [NI] = '{0, 0, 2, 1, 0, 2};  // NONE, NONE, EVEN, ODD, NONE, EVEN
  localparam int SBS    [NI] = '{1, 1, 1, 1, 2, 2};
  localparam int PERS   [NI] = '{1, 16, 3, 5, 0, 2}; // 0 = random ticks
  localparam int DIRW   [NI] = '{'hA5, 'hA5, 'h07, 'h07, 'h41, 'h1A3};
  // Hand-derived line sequences, leftmost character transmitted first.
  localparam logic [15:0] DIREXP [NI] = '{
    16'b0101001011,
    16'b0101001011,
    16'b01110000011,
    16'b01110000001,
    16'b0100000111,
    16'b0110001011111
  };
  localparam int DIRLEN [NI] = '{10, 10, 11, 11, 10, 13};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int      DB  = DBS[g];
    localparam parity_t PAR = parity_t'(PARS_I[g]);
    localparam int      SB  = SBS[g];
    localparam int      PER = PERS[g];
    localparam int      LEN = 1 + DB + ((PAR != PARITY_NONE) ? 1 : 0) + SB;

    logic          rst   = 1'b1;
    logic          tick  = 1'b0;
    logic          valid = 1'b0;
    logic [DB-1:0] data  = '0;
    logic          txReady;
    logic          line;
    logic          busy;
    logic          fdone;

    uart_tx_framer #(.DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB)) dut (
      .clk           (clk),
      .rst           (rst),
      .baudTick      (tick),
      .txValid       (valid),
      .txData        (data),
      .txReady       (txReady),
      .transmitOutput(line),
      .busy          (busy),
      .frameDone     (fdone)
    );

    // Model state
    bitq_t         pend;
    bit            in_frame = 0;
    bit            held     = 0;
    bit            h0;
    logic [DB-1:0] hword;
    bit            m_line   = 1;
    bit            m_fd     = 0;
    bit            acc_last = 0;
    bit            rec[$];
    int            fd_cnt   = 0;
    bit            fin      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL inst%0d %s: got %0h expected %0h at %0t", g, name, act, exp, $time);
      end
    endtask

    function automatic bitq_t frame_bits(input logic [DB-1:0] w);
      bitq_t q;
      bit    p;
      p = 0;
      q.push_back(1'b0);
      for (int i = 0; i < DB; i++) begin
        q.push_back(w[i]);
        p ^= w[i];
      end
      if (PAR == PARITY_EVEN) q.push_back(p);
      else if (PAR == PARITY_ODD) q.push_back(!p);
      for (int i = 0; i < SB; i++) q.push_back(1'b1);
      return q;
    endfunction

    function automatic logic rec_at(input int i);
      if (i < rec.size()) return rec[i];
      return 1'bx;
    endfunction

    // Tick source
    initial begin
      int c;
      c = 0;
      forever begin
        @(negedge clk);
        c++;
        if (PER == 1) tick = 1'b1;
        else if (PER == 0) tick = ($urandom_range(3) == 0);
        else tick = ((c % PER) == 0);
      end
    end

    // Model update and per-cycle compare, just after each active edge.
    initial begin
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          pend.delete();
          in_frame = 0;
          held     = 0;
          m_line   = 1;
          m_fd     = 0;
          acc_last = 0;
        end else begin
          h0       = held;
          m_fd     = 0;
          acc_last = 0;
          if (tick) begin
            if (in_frame && pend.size() == 0) begin
              m_fd     = 1;
              in_frame = 0;
            end
            if (!in_frame) begin
              if (held) begin
                pend     = frame_bits(hword);
                held     = 0;
                in_frame = 1;
                m_line   = pend.pop_front();
              end else begin
                m_line = 1;
              end
            end else begin
              m_line = pend.pop_front();
            end
          end
          if (valid && !h0) begin
            held     = 1;
            hword    = data;
            acc_last = 1;
          end
        end
        if (!rst && tick) rec.push_back(line);
        if (fdone === 1'b1) fd_cnt++;
        check("line", line, m_line);
        check("txReady", txReady, !held);
        check("busy", busy, in_frame);
        check("frameDone", fdone, m_fd);
      end
    end

    task automatic send_wait(input logic [DB-1:0] w, input bit keep);
      bit got;
      got   = 0;
      valid = 1'b1;
      data  = w;
      for (int n = 0; n < 3000 && !got; n++) begin
        @(negedge clk);
        got = acc_last;
      end
      if (!got) check("accept_timeout", 0, 1);
      if (!keep) valid = 1'b0;
    endtask

    task automatic wait_rec(input int n);
      for (int k = 0; k < 3000 && rec.size() < n; k++) @(negedge clk);
      if (rec.size() < n) check("tick_timeout", rec.size(), n);
    endtask

    // Stimulus
    initial begin
      logic [15:0] ev;
      bitq_t       q;
      bitq_t       q2;
      int          base;
      int          fd0;
      int          z;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_line", line, 1);
      check("rst_txReady", txReady, 1);
      check("rst_busy", busy, 0);
      check("rst_frameDone", fdone, 0);
      rst = 1'b0;

      // Pin the model against hand-derived frames.
      ev = DIREXP[g];
      q  = frame_bits(DB'(DIRW[g]));
      check("model_len", q.size(), DIRLEN[g]);
      for (int i = 0; i < DIRLEN[g] && i < q.size(); i++)
        check("model_bit", q[i], ev[DIRLEN[g]-1-i]);

      // Single directed frame, DUT line against the literal sequence.
      send_wait(DB'(DIRW[g]), 0);
      base = rec.size();
      fd0  = fd_cnt;
      wait_rec(base + DIRLEN[g] + 1);
      for (int i = 0; i < DIRLEN[g]; i++)
        check("dir_bit", rec_at(base + i), ev[DIRLEN[g]-1-i]);
      check("dir_idle_after", rec_at(base + DIRLEN[g]), 1);
      repeat (2) @(negedge clk);
      check("dir_frameDone_cnt", fd_cnt - fd0, 1);
      check("dir_busy_after", busy, 0);

      // Back-to-back: second word accepted mid-frame, no idle bit between.
      send_wait(DB'('h55), 1);
      check("b2b_ready_low", txReady, 0);
      base = rec.size();
      fd0  = fd_cnt;
      send_wait(DB'('hAA), 0);
      q  = frame_bits(DB'('h55));
      q2 = frame_bits(DB'('hAA));
      foreach (q2[i]) q.push_back(q2[i]);
      check("b2b_len", q.size(), 2 * DIRLEN[g] - ((g == 4 || g == 5) ? 2 * (DIRLEN[g] - LEN) : 0));
      wait_rec(base + q.size() + 1);
      foreach (q[i]) check("b2b_bit", rec_at(base + i), q[i]);
      check("b2b_idle_after", rec_at(base + q.size()), 1);
      repeat (2) @(negedge clk);
      check("b2b_frameDone_cnt", fd_cnt - fd0, 2);

      // Reset in the middle of the data bits with a word held.
      send_wait({DB{1'b1}}, 1);
      base = rec.size();
      send_wait(DB'($urandom), 0);
      wait_rec(base + 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstmid_line", line, 1);
      check("rstmid_txReady", txReady, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_frameDone", fdone, 0);
      base = rec.size();
      fd0  = fd_cnt;
      wait_rec(base + 3 * LEN);
      z = 0;
      for (int i = base; i < rec.size(); i++) if (rec[i] == 1'b0) z++;
      check("rstmid_no_frame", z, 0);
      check("rstmid_no_frameDone", fd_cnt - fd0, 0);

      // Random traffic with occasional resets.
      for (int c = 0; c < 2500; c++) begin
        @(negedge clk);
        rst = ($urandom_range(1499) == 0);
        if (!valid || acc_last) begin
          valid = ($urandom_range(3) != 0);
          data  = DB'($urandom);
        end
      end
      rst   = 1'b0;
      valid = 1'b0;
      for (int k = 0; k < 5000 && (in_frame || held); k++) @(negedge clk);
      if (in_frame || held) check("drain_timeout", 0, 1);
      repeat (2) @(negedge clk);
      fin = 1;
    end
  end

  initial begin
    bit all;
    all = 0;
    for (int k = 0; k < 60000 && !all; k++) begin
      @(negedge clk);
      all = inst[0].fin && inst[1].fin && inst[2].fin &&
            inst[3].fin && inst[4].fin && inst[5].fin;
    end
    if (!all) begin
      checks++;
      errors++;
      $display("FAIL global_timeout: instances finished %0b required all", all);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
